// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared state type and default sizing for the sequence detector
package seq_detect_pkg;
    typedef enum logic {UNCFG, RUN} sd_state_t;
    localparam int SD_MAX_LEN = 8;
    localparam int SD_CNT_W   = 16;
endpackage

// File: rtl/sd_sat_counter.sv
// sd_sat_counter: clearable up-counter that sticks at all-ones instead of wrapping
module sd_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !(&count))
            count <= count + 1'b1;
endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable serial pattern detector with Mealy match,
// registered match and a saturating match counter
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = SD_MAX_LEN,
    parameter int CNT_W   = SD_CNT_W,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap_en,
    input  logic               din_valid,
    input  logic               din,
    output logic               armed,
    output logic               cfg_err,
    output logic               match,
    output logic               match_q,
    output logic [CNT_W-1:0]   match_cnt
);
    sd_state_t          state, state_nx;
    logic [MAX_LEN-1:0] hist, pat_s, cand, mask;
    logic [LEN_W-1:0]   len_s, fill, fill_inc;
    logic               ovl_s, legal, enough;

    assign legal    = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
    assign cand     = {hist[MAX_LEN-2:0], din};
    assign enough   = ({1'b0, fill} + 1'b1) >= {1'b0, len_s};
    assign fill_inc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
    assign armed    = (state == RUN);

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len_s));
    end

    assign match = armed && din_valid && !cfg_load && enough && (((cand ^ pat_s) & mask) == '0);

    always_comb begin
        state_nx = state;
        if (cfg_load)
            state_nx = legal ? RUN : UNCFG;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= UNCFG;
        else
            state <= state_nx;

    // A non-overlapping hit flushes history so the next hit needs len fresh bits
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hist    <= '0;
            fill    <= '0;
            pat_s   <= '0;
            len_s   <= '0;
            ovl_s   <= 1'b0;
            cfg_err <= 1'b0;
            match_q <= 1'b0;
        end else begin
            match_q <= match;
            if (cfg_load) begin
                cfg_err <= !legal;
                hist    <= '0;
                fill    <= '0;
                if (legal) begin
                    pat_s <= pat;
                    len_s <= pat_len;
                    ovl_s <= overlap_en;
                end
            end else if (armed && din_valid) begin
                hist <= (match && !ovl_s) ? '0 : cand;
                fill <= (match && !ovl_s) ? '0 : fill_inc;
            end
        end

    sd_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match),
        .clr   (cfg_load),
        .count (match_cnt)
    );
endmodule
